bin_clock_seg7_scan: RTL and testbench
======================================

# bin_clock_seg7_scan

Display-side decoder for the binary time produced by the binary clock core. It takes the core's hour, minute, seconds and meridiem values and drives a six-digit, time-multiplexed common-cathode 7-segment display reading HH MM SS. Each digit gets a programmable dwell time and a ghost-blanking window. Inputs are snapshotted once per scan frame so a frame never mixes two different times.

## Interface

- DIGIT_CYCLES, 1000: clock cycles each digit is selected; legal range ≥ 4.
- BLANK_CYCLES, 16: cycles at the start of each digit slot with all digits off; legal range 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- clk_i  in  1  single clock.
- reset_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  when 0, all digits are forced off; scanning continues.
- hour_i  in  4  hour: 1–12 valid, 0 displays as 12, 13–15 invalid.
- minute_i  in  6  minute: 0–59 valid, 60–63 invalid.
- seconds_i  in  6  seconds: 0–59 valid, 60–63 invalid.
- pm_i  in  1  meridiem (0 = AM, 1 = PM).
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp_o  out  1  decimal point, active-high.
- digit_n_o  out  6  digit enables, active-low; bit 5 = hour tens (leftmost), bit 0 = seconds ones.
- frame_o  out  1  one-cycle pulse at the start of each frame.

## Operation

- **Counters.**
  - pcnt runs 0..DIGIT_CYCLES-1.
  - When pcnt wraps, digit index d advances 0→5 and then wraps to 0.
  - d = 0 is hour tens; d = 5 is seconds ones.
- **Snapshot.**
  - hour_i, minute_i, seconds_i and pm_i load into snapshot registers on the edge where (d, pcnt) moves from (5, DIGIT_CYCLES-1) to (0, 0).
  - All display content comes from the snapshot only.
- **Digit content.**
  - Hour tens shows "1" for hours 10, 11, 12 and 0; otherwise blank (seg = 0).
  - Hour ones shows hour mod 10, with hour 0 treated as 12, so it shows 2.
  - Minute and seconds digits show value/10 and value mod 10.
- **Invalid values.** Both digits of an invalid field show a dash (seg = 7'b1000000). Other fields are unaffected.
- **Decimal points.**
  - d = 1 and d = 3 (colon substitute): dp lit when the seconds snapshot is even. If seconds is invalid, dp is off.
  - d = 5: dp = pm snapshot.
  - All other digits: dp = 0.
- **Digit enable.** digit_n_o[5-d] = 0 only when pcnt ≥ BLANK_CYCLES and enable_i = 1. All other bits are 1.
- **Glyphs 0–9 (hex).** 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.

## Timing

- **Reset (asynchronous).**
  - pcnt = 0, d = 0, snapshot = 0.
  - Snapshot 0 displays 12:00:00 AM until the first frame-end load.
- **Output reset values.** seg_o = 0, dp_o = 0, digit_n_o = 6'b111111, frame_o = 0.
- **Output registration.** All outputs are registered. Outputs in cycle t+1 reflect (d, pcnt, snapshot, enable_i) in cycle t. Latency is one cycle.
- **frame_o.** High in the cycle after the counter state (0, 0).
- **Frame period.** Exactly 6 × DIGIT_CYCLES cycles. Each digit is lit for DIGIT_CYCLES − BLANK_CYCLES cycles.
- **Mid-frame input changes.** Ignored until the next frame-end snapshot.
- **enable_i.**
  - enable_i falling blanks digit_n_o one cycle later.
  - Counters and snapshot keep running.
- **Reset mid-frame.** Returns immediately to the reset values. Scanning restarts at d = 0 after deassertion.

## Structure

- **Shared package (bin_clock_pkg).**
  - SEG_DIGIT[0:9] glyph constants and SEG_DASH.
  - Digit index localparams.
  - div10 function for 0–63 producing tens and ones, built from comparisons with no divider.
- **Sub-module bin_clock_seg7_enc.**
  - Combinational.
  - Inputs: selected field value, digit position and valid flag.
  - Output: seg pattern.
- **Top level.** Holds the counters, snapshot, digit mux and output registers.

## Test plan

- **Reset.** Hold reset_ni = 0 → digit_n_o = 111111, seg_o = 0, dp_o = 0, frame_o = 0. After release, the first frame (DIGIT_CYCLES = 8, BLANK_CYCLES = 2) shows segments 06, 5B, 3F, 3F, 3F, 3F.
- **Normal time.** hour = 10, min = 37, sec = 18, pm = 1 held across a frame boundary → next frame shows 06, 3F, 4F, 07, 06, 7F. dp lit on d = 1, 3 and 5. Each digit enable is low for 6 of 8 cycles.
- **Invalid minutes and leading blank.** min = 61, hour = 6, sec = 7 → minute digits both show 40. Hour tens seg = 00, hour ones 7D. dp on d = 1, 3 is off (sec odd).
- **Snapshot coherence.** Change hour 3 → 4 while d = 2 → the current frame still shows 4F on d = 1. The next frame shows 66. frame_o pulses once per 48 cycles.
- **enable_i.** Drive enable_i = 0 for 20 cycles → digit_n_o = 111111 from the next cycle. frame_o keeps pulsing every 48 cycles.
- **Reset mid-frame.** Assert reset at d = 3 → outputs return to reset values immediately. After deassertion, the display restarts at d = 0 showing 12:00:00.

Source files
------------

// File: rtl/bin_clock_pkg.sv
// Shared constants and helpers for the binary-clock display path:
// 7-segment glyphs, digit position indices and a divider-free split
// of a 0..63 value into tens and ones.
package bin_clock_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scan positions, left to right on the display.
    localparam logic [2:0] DIG_HOUR_TENS = 3'd0;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd1;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd2;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd3;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd4;
    localparam logic [2:0] DIG_SEC_ONES  = 3'd5;
    localparam int         NUM_DIGITS    = 6;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Tens/ones split by a comparison ladder; the subtraction result
    // always fits in four bits because it is below ten.
    function automatic bcd2_t div10(input logic [5:0] v);
        bcd2_t r;
        if (v >= 6'd60) begin
            r.tens = 4'd6;
            r.ones = 4'(v - 6'd60);
        end else if (v >= 6'd50) begin
            r.tens = 4'd5;
            r.ones = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            r.tens = 4'd4;
            r.ones = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            r.tens = 4'd3;
            r.ones = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            r.tens = 4'd2;
            r.ones = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            r.tens = 4'd1;
            r.ones = 4'(v - 6'd10);
        end else begin
            r.tens = 4'd0;
            r.ones = v[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_clock_seg7_enc.sv
// Combinational glyph encoder for one display position. Takes the
// already-selected field value (hour, minute or seconds), which digit of
// that field is being drawn, and whether the field is in range.
module bin_clock_seg7_enc
    import bin_clock_pkg::*;
(
    input  logic [5:0] value_i,
    input  logic [2:0] digit_i,
    input  logic       valid_i,
    output logic [6:0] seg_o
);

    logic [5:0] w_value_adj;
    bcd2_t      w_bcd;

    // Hour 0 is shown as 12, which only matters for the hour-ones digit.
    assign w_value_adj = (digit_i == DIG_HOUR_ONES && value_i == 6'd0) ? 6'd12 : value_i;
    assign w_bcd       = div10(w_value_adj);

    // Pick the glyph for this position; out-of-range fields draw a dash.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!valid_i) begin
            seg_o = SEG_DASH;
        end else begin
            case (digit_i)
                DIG_HOUR_TENS: begin
                    // Leading "1" for 10, 11, 12 and for 0 (displayed as 12).
                    if (value_i == 6'd0 || value_i >= 6'd10)
                        seg_o = SEG_DIGIT[1];
                    else
                        seg_o = SEG_BLANK;
                end
                DIG_HOUR_ONES,
                DIG_MIN_ONES,
                DIG_SEC_ONES:  seg_o = SEG_DIGIT[w_bcd.ones];
                DIG_MIN_TENS,
                DIG_SEC_TENS:  seg_o = SEG_DIGIT[w_bcd.tens];
                default:       seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin_clock_seg7_scan.sv
// Six-digit multiplexed 7-segment driver for HH MM SS. A slot counter
// dwells DIGIT_CYCLES on each digit with the first BLANK_CYCLES dark to
// suppress ghosting. Time inputs are captured once per frame so a frame
// never shows a mixture of two times. All outputs are registered.
module bin_clock_seg7_scan
    import bin_clock_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       enable_i,
    input  logic [3:0] hour_i,
    input  logic [5:0] minute_i,
    input  logic [5:0] seconds_i,
    input  logic       pm_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [5:0] digit_n_o,
    output logic       frame_o
);

    localparam int PW = $clog2(DIGIT_CYCLES);

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_d;
    logic [3:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_pm;

    logic          w_pcnt_last;
    logic          w_frame_end;
    logic          w_frame_start;
    logic          w_hour_valid;
    logic          w_min_valid;
    logic          w_sec_valid;
    logic [5:0]    w_field;
    logic          w_field_valid;
    logic [6:0]    w_seg_next;
    logic          w_dp_next;
    logic          w_lit;
    logic [5:0]    w_digit_n_next;

    assign w_pcnt_last   = (r_pcnt == PW'(DIGIT_CYCLES - 1));
    assign w_frame_end   = w_pcnt_last && (r_d == DIG_SEC_ONES);
    assign w_frame_start = (r_pcnt == '0) && (r_d == DIG_HOUR_TENS);

    // Dwell counter and digit index; the index advances when the dwell wraps.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pcnt <= '0;
            r_d    <= DIG_HOUR_TENS;
        end else if (w_pcnt_last) begin
            r_pcnt <= '0;
            r_d    <= (r_d == DIG_SEC_ONES) ? DIG_HOUR_TENS : r_d + 3'd1;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // Capture the time on the last cycle of a frame so the next frame is coherent.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
            r_pm   <= 1'b0;
        end else if (w_frame_end) begin
            r_hour <= hour_i;
            r_min  <= minute_i;
            r_sec  <= seconds_i;
            r_pm   <= pm_i;
        end
    end

    // Hour 0 is legal (shown as 12); 13..15 are not.
    assign w_hour_valid = (r_hour <= 4'd12);
    assign w_min_valid  = (r_min  <  6'd60);
    assign w_sec_valid  = (r_sec  <  6'd60);

    // Route the snapshot field that owns the current digit to the encoder.
    always_comb begin
        w_field       = '0;
        w_field_valid = 1'b0;
        case (r_d)
            DIG_HOUR_TENS, DIG_HOUR_ONES: begin
                w_field       = {2'b00, r_hour};
                w_field_valid = w_hour_valid;
            end
            DIG_MIN_TENS, DIG_MIN_ONES: begin
                w_field       = r_min;
                w_field_valid = w_min_valid;
            end
            DIG_SEC_TENS, DIG_SEC_ONES: begin
                w_field       = r_sec;
                w_field_valid = w_sec_valid;
            end
            default: begin
                w_field       = '0;
                w_field_valid = 1'b0;
            end
        endcase
    end

    bin_clock_seg7_enc u_enc (
        .value_i (w_field),
        .digit_i (r_d),
        .valid_i (w_field_valid),
        .seg_o   (w_seg_next)
    );

    // Decimal points: blinking colon substitute on hour/minute ones, PM flag on the last digit.
    always_comb begin
        w_dp_next = 1'b0;
        case (r_d)
            DIG_HOUR_ONES, DIG_MIN_ONES: w_dp_next = w_sec_valid && !r_sec[0];
            DIG_SEC_ONES:                w_dp_next = r_pm;
            default:                     w_dp_next = 1'b0;
        endcase
    end

    // A digit is driven only after its ghost-blanking window and while enabled.
    assign w_lit = enable_i && (r_pcnt >= PW'(BLANK_CYCLES));

    // Active-low digit strobes; bit 5 is the leftmost digit (index 0).
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_en
            assign w_digit_n_next[gi] = ~(w_lit && (r_d == 3'(NUM_DIGITS - 1 - gi)));
        end
    endgenerate

    // Output registers give a uniform one-cycle latency on every output.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            seg_o     <= SEG_BLANK;
            dp_o      <= 1'b0;
            digit_n_o <= '1;
            frame_o   <= 1'b0;
        end else begin
            seg_o     <= w_seg_next;
            dp_o      <= w_dp_next;
            digit_n_o <= w_digit_n_next;
            frame_o   <= w_frame_start;
        end
    end

endmodule

// File: tb/tb_bin_clock_seg7_scan.sv
// Scoreboard bench for the 7-segment scanner: each scenario pushes the
// expected per-digit glyph/dp for a frame, and a frame checker pops and
// compares them while also checking digit strobes and frame pulses.
module tb_bin_clock_seg7_scan;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = 6 * DC;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       enable_i = 1'b1;
    logic [3:0] hour_i = '0;
    logic [5:0] minute_i = '0;
    logic [5:0] seconds_i = '0;
    logic       pm_i = 1'b0;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [5:0] digit_n_o;
    logic       frame_o;

    int   checks = 0;
    int   failures = 0;
    logic en_prev = 1'b1;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];

    logic [6:0] glyph [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bin_clock_seg7_scan #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .enable_i  (enable_i),
        .hour_i    (hour_i),
        .minute_i  (minute_i),
        .seconds_i (seconds_i),
        .pm_i      (pm_i),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .digit_n_o (digit_n_o),
        .frame_o   (frame_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference glyph for digit d of a time.
    function automatic logic [6:0] exp_seg(input int d, input int h, input int m, input int s);
        int hd;
        case (d)
            0: if (h > 12) return 7'h40; else return (h == 0 || h >= 10) ? 7'h06 : 7'h00;
            1: begin
                if (h > 12) return 7'h40;
                hd = (h == 0) ? 12 : h;
                return glyph[hd % 10];
            end
            2: return (m > 59) ? 7'h40 : glyph[m / 10];
            3: return (m > 59) ? 7'h40 : glyph[m % 10];
            4: return (s > 59) ? 7'h40 : glyph[s / 10];
            default: return (s > 59) ? 7'h40 : glyph[s % 10];
        endcase
    endfunction

    function automatic logic exp_dp(input int d, input int s, input int pm);
        if (d == 1 || d == 3) return (s < 60) && (s % 2 == 0);
        if (d == 5) return pm != 0;
        return 1'b0;
    endfunction

    task automatic push_frame(input int h, input int m, input int s, input int pm);
        exp_t e;
        for (int d = 0; d < 6; d++) begin
            e.seg = exp_seg(d, h, m, s);
            e.dp  = exp_dp(d, s, pm);
            sb.push_back(e);
        end
    endtask

    // Advance one cycle; remember the enable the DUT sampled at that edge.
    task automatic step();
        @(posedge clk_i);
        en_prev = enable_i;
        #1;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (frame_o !== 1'b1 && n < 4 * FRAME) begin
            step();
            n++;
        end
        checks++;
        if (frame_o !== 1'b1) begin
            failures++;
            $display("FAIL %s frame_wait: frame_o=%b after %0d cycles, required 1", tag, frame_o, n);
        end
    endtask

    task automatic next_frame(input string tag);
        step();
        wait_frame(tag);
    endtask

    // Check one full frame starting in the frame_o cycle; ends at the next frame start.
    task automatic check_frame(input string tag);
        exp_t e;
        logic [5:0] exp_dn;
        logic exp_lit;
        int slot;
        int pos;
        int errs;
        errs = failures;
        e.seg = '0;
        e.dp  = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            slot = c / DC;
            pos  = c % DC;
            if (pos == 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s scoreboard_empty: slot %0d has no expectation", tag, slot);
                end else begin
                    e = sb.pop_front();
                end
            end
            checks++;
            if (frame_o !== (c == 0)) begin
                failures++;
                $display("FAIL %s frame_o c%0d: got %b required %b", tag, c, frame_o, (c == 0));
            end
            exp_lit = en_prev && (pos >= BC);
            exp_dn  = exp_lit ? ~(6'b000001 << (5 - slot)) : 6'b111111;
            checks++;
            if (digit_n_o !== exp_dn) begin
                failures++;
                $display("FAIL %s digit_n d%0d c%0d: got %b required %b", tag, slot, c, digit_n_o, exp_dn);
            end
            if (pos >= BC) begin
                checks++;
                if (seg_o !== e.seg) begin
                    failures++;
                    $display("FAIL %s seg d%0d c%0d: got %h required %h", tag, slot, c, seg_o, e.seg);
                end
                checks++;
                if (dp_o !== e.dp) begin
                    failures++;
                    $display("FAIL %s dp d%0d c%0d: got %b required %b", tag, slot, c, dp_o, e.dp);
                end
            end
            step();
        end
        $display("frame %s: %0d new errors", tag, failures - errs);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (digit_n_o !== 6'b111111) begin
            failures++;
            $display("FAIL %s digit_n: got %b required 111111", tag, digit_n_o);
        end
        checks++;
        if (seg_o !== 7'h00) begin
            failures++;
            $display("FAIL %s seg: got %h required 00", tag, seg_o);
        end
        checks++;
        if (dp_o !== 1'b0) begin
            failures++;
            $display("FAIL %s dp: got %b required 0", tag, dp_o);
        end
        checks++;
        if (frame_o !== 1'b0) begin
            failures++;
            $display("FAIL %s frame_o: got %b required 0", tag, frame_o);
        end
    endtask

    // Apply a time now; the frame after the next boundary must show it.
    task automatic run_frame(input int h, input int m, input int s, input int pm, input string tag);
        hour_i    = 4'(h);
        minute_i  = 6'(m);
        seconds_i = 6'(s);
        pm_i      = 1'(pm);
        push_frame(h, m, s, pm);
        next_frame(tag);
        check_frame(tag);
    endtask

    task automatic test_reset();
        hour_i = 4'd7;
        minute_i = 6'd21;
        repeat (3) step();
        check_reset_outputs("reset_hold");
        push_frame(0, 0, 0, 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        wait_frame("reset_first");
        check_frame("reset_first");
    endtask

    task automatic test_normal();
        run_frame(10, 37, 18, 1, "normal");
    endtask

    task automatic test_invalid_minutes();
        run_frame(6, 61, 7, 0, "invalid_min");
    endtask

    task automatic test_coherence();
        run_frame(3, 12, 44, 0, "coh_setup");
        // Inputs are still hour 3, so this frame shows 3 despite the change at d=2.
        push_frame(3, 12, 44, 0);
        fork
            check_frame("coh_during");
            begin
                repeat (2 * DC + 1) @(negedge clk_i);
                hour_i = 4'd4;
            end
        join
        push_frame(4, 12, 44, 0);
        check_frame("coh_after");
    endtask

    task automatic test_enable();
        push_frame(4, 12, 44, 0);
        fork
            check_frame("enable_low");
            begin
                repeat (10) @(negedge clk_i);
                enable_i = 1'b0;
                repeat (20) @(negedge clk_i);
                enable_i = 1'b1;
            end
        join
        push_frame(4, 12, 44, 0);
        check_frame("enable_back");
    endtask

    task automatic test_back_to_back();
        int pat [4][4] = '{'{13, 59, 60, 1}, '{0, 0, 59, 1}, '{12, 5, 2, 0}, '{9, 60, 63, 0}};
        for (int i = 0; i < 4; i++) begin
            run_frame(pat[i][0], pat[i][1], pat[i][2], pat[i][3], $sformatf("b2b%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        hour_i = 4'd11;
        minute_i = 6'd45;
        seconds_i = 6'd30;
        pm_i = 1'b1;
        repeat (3 * DC + 3) step();
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("rst_mid_now");
        repeat (3) step();
        check_reset_outputs("rst_mid_hold");
        push_frame(0, 0, 0, 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        wait_frame("rst_mid_restart");
        check_frame("rst_mid_restart");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_invalid_minutes();
        test_coherence();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
